dot_product_tree: RTL and testbench
===================================

// Module: dot_product_tree
// PURPOSE
//  Pipelined signed dot-product engine of the MVM datapath: multiplies LANES vector/matrix element pairs
//  per beat, reduces them through a registered adder tree, and emits one partial sum per beat.
//  Sits directly upstream of accum: result/ovalid/ofirst/olast drive accum data/ivalid/first/last.
//  Fully pipelined, one beat per cycle, no backpressure.
// PARAMETERS
//  LANES   8   element pairs per beat; power of two, >= 2
//  IWIDTH  8   signed width of each vector/matrix element
//  OWIDTH  32  signed width of result; must be >= 2*IWIDTH + $clog2(LANES), else elaboration $error
// PORTS
//  clk     in   1              clock, all state on rising edge
//  rst     in   1              asynchronous, active-high reset
//  ivalid  in   1              input beat valid
//  first   in   1              beat is first of a dot-product row (meaningful only with ivalid)
//  last    in   1              beat is last of a row (meaningful only with ivalid)
//  vec     in   LANES*IWIDTH   vector elements; lane i = vec[i*IWIDTH +: IWIDTH], signed
//  mat     in   LANES*IWIDTH   matrix elements; lane i = mat[i*IWIDTH +: IWIDTH], signed
//  result  out  OWIDTH         signed sum over i of vec[i]*mat[i]
//  ovalid  out  1              result valid
//  ofirst  out  1              first flag aligned to result
//  olast   out  1              last flag aligned to result
// BEHAVIOUR
//  - Reset (async, immediate): result=0, ovalid=0, ofirst=0, olast=0; all internal valid/first/last and data regs 0.
//  - Stage 0: LANES registered products, each 2*IWIDTH bits signed. Stages 1..log2(LANES): pairwise adds,
//    operand width grows 1 bit per level; final sum sign-extended to OWIDTH. No saturation, no overflow possible.
//  - Latency L = 1 + $clog2(LANES) cycles (4 at default): beat sampled at edge n appears on outputs after edge n+L-1.
//  - Sideband pipe (valid, first&ivalid, last&ivalid) loads every cycle; ofirst/olast are 0 whenever ovalid=0.
//  - Data regs of a stage load only when that stage's incoming valid=1, else hold; result holds last value on bubbles.
//  - Back-to-back beats: one result per cycle, order preserved, flags stay aligned to their own beat.
//  - first and last both set on one beat: both propagate (single-beat row).
//  - Reset mid-operation: in-flight beats are discarded; no ovalid after reset release until a new beat traverses L cycles.
//  - first/last/vec/mat ignored when ivalid=0.
// CONFIGURATION
//  DOT_PRODUCT_INPUT_REG_EN defined: extra register stage on ivalid/first/last/vec/mat before multiply;
//    L = 2 + $clog2(LANES) (5 at default); reset value 0; otherwise identical.
//  Undefined: inputs feed the multiplier stage directly; L = 1 + $clog2(LANES).
// STRUCTURE
//  - mvm_pkg: default LANES/IWIDTH/OWIDTH constants, typedef for the {valid,first,last} sideband struct,
//    function tree_levels(LANES) = $clog2(LANES).
//  - Sub-module dot_tree_level: one registered adder level (N inputs of width W -> N/2 outputs of W+1, valid-gated load);
//    instantiated $clog2(LANES) times from a generate loop.
// TESTING (LANES=8, IWIDTH=8, OWIDTH=32, macro undefined unless stated)
//  1. vec=all 1, mat=all 1, ivalid=first=last=1 one cycle -> after 4 cycles result=8, ovalid=ofirst=olast=1 for one cycle.
//  2. vec=all -128, mat=all -128 -> result=131072; vec=all -128, mat=all 127 -> result=-130048 (width extremes).
//  3. Three back-to-back beats lanes {1..8}x1 (first on #1), all 2x3, all -1x5 (last on #3) -> results 36, 48, -40
//     on consecutive cycles; ofirst only with 36, olast only with -40.
//  4. Beat (all 1x1), one ivalid=0 bubble with vec/mat=all 127, beat (all 2x2) -> results 8, gap (ovalid=0, result holds 8), 32.
//  5. Two beats in flight, rst pulsed mid-cycle -> outputs 0 immediately; ovalid stays 0 for >= 8 cycles after release.
//  6. DOT_PRODUCT_INPUT_REG_EN defined, repeat scenario 1 -> result=8 appears after 5 cycles; chained into accum,
//     scenario 3 yields accum result=44 with ovalid=1.

Source files
------------

// File: rtl/mvm_pkg.sv
// ============================================================================
// Module  : mvm_pkg
// Brief   : Shared constants, sideband type and helpers for the MVM datapath.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mvm_pkg;

    localparam int c_LANES_DEFAULT  = 8;
    localparam int c_IWIDTH_DEFAULT = 8;
    localparam int c_OWIDTH_DEFAULT = 32;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } sideband_t;

    function automatic int tree_levels(input int lanes);
        return $clog2(lanes);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dot_product_tree_if.sv
// ============================================================================
// Module  : dot_product_tree_if
// Brief   : Beat-in / partial-sum-out bundle of the dot-product engine.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface dot_product_tree_if #(
    parameter int LANES  = 8,
    parameter int IWIDTH = 8,
    parameter int OWIDTH = 32
) ();

    logic                      ivalid;
    logic                      first;
    logic                      last;
    logic [LANES*IWIDTH-1:0]   vec;
    logic [LANES*IWIDTH-1:0]   mat;
    logic [OWIDTH-1:0]         result;
    logic                      ovalid;
    logic                      ofirst;
    logic                      olast;

    modport master (
        output ivalid, first, last, vec, mat,
        input  result, ovalid, ofirst, olast
    );

    modport slave (
        input  ivalid, first, last, vec, mat,
        output result, ovalid, ofirst, olast
    );

endinterface

`default_nettype wire

// File: rtl/dot_tree_level.sv
// ============================================================================
// Module  : dot_tree_level
// Brief   : One registered pairwise adder level: N x W -> N/2 x (W+1).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dot_tree_level
    import mvm_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 16
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire sideband_t             i_sb,
    input  wire logic [N*W-1:0]        i_data,
    output sideband_t                  o_sb,
    output logic [(N/2)*(W+1)-1:0]     o_data
);

    logic [(N/2)*(W+1)-1:0] w_next;
    logic [(N/2)*(W+1)-1:0] r_data;
    sideband_t              r_sb;

    for (genvar j = 0; j < N/2; j++) begin : g_pair
        assign w_next[j*(W+1) +: W+1] = (W+1)'($signed(i_data[(2*j)*W +: W]))
                                      + (W+1)'($signed(i_data[(2*j+1)*W +: W]));
    end

    // Sideband always advances; data only on valid beats so results hold across bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sb   <= '0;
            r_data <= '0;
        end else begin
            r_sb <= i_sb;
            if (i_sb.valid) begin
                r_data <= w_next;
            end
        end
    end

    assign o_sb   = r_sb;
    assign o_data = r_data;

endmodule

`default_nettype wire

// File: rtl/dot_product_tree.sv
// ============================================================================
// Module  : dot_product_tree
// Brief   : Pipelined signed dot product (multiply + registered adder tree).
//           DOT_PRODUCT_INPUT_REG_EN adds an input register stage (+1 latency).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dot_product_tree
    import mvm_pkg::*;
#(
    parameter int LANES  = c_LANES_DEFAULT,
    parameter int IWIDTH = c_IWIDTH_DEFAULT,
    parameter int OWIDTH = c_OWIDTH_DEFAULT
) (
    input  wire logic          clk,
    input  wire logic          rst,
    dot_product_tree_if.slave  bus
);

    localparam int c_LEVELS = tree_levels(LANES);
    localparam int c_PW     = 2 * IWIDTH;
    localparam int c_SW     = c_PW + c_LEVELS;

    if (LANES < 2 || (LANES & (LANES - 1)) != 0) begin : g_lanes_check
        $error("dot_product_tree: LANES must be a power of two >= 2");
    end
    if (OWIDTH < c_SW) begin : g_owidth_check
        $error("dot_product_tree: OWIDTH narrower than 2*IWIDTH + clog2(LANES)");
    end

    sideband_t                  w_raw_sb;
    sideband_t                  w_in_sb;
    logic [LANES*IWIDTH-1:0]    w_vec;
    logic [LANES*IWIDTH-1:0]    w_mat;

    assign w_raw_sb.valid = bus.ivalid;
    assign w_raw_sb.first = bus.first & bus.ivalid;
    assign w_raw_sb.last  = bus.last  & bus.ivalid;

`ifdef DOT_PRODUCT_INPUT_REG_EN
    sideband_t                  r_in_sb;
    logic [LANES*IWIDTH-1:0]    r_vec;
    logic [LANES*IWIDTH-1:0]    r_mat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_sb <= '0;
            r_vec   <= '0;
            r_mat   <= '0;
        end else begin
            r_in_sb <= w_raw_sb;
            if (bus.ivalid) begin
                r_vec <= bus.vec;
                r_mat <= bus.mat;
            end
        end
    end

    assign w_in_sb = r_in_sb;
    assign w_vec   = r_vec;
    assign w_mat   = r_mat;
`else
    assign w_in_sb = w_raw_sb;
    assign w_vec   = bus.vec;
    assign w_mat   = bus.mat;
`endif

    logic signed [c_PW-1:0] w_prod [LANES];
    logic signed [c_PW-1:0] r_prod [LANES];
    sideband_t              r_sb0;

    for (genvar i = 0; i < LANES; i++) begin : g_mult
        assign w_prod[i] = $signed(w_vec[i*IWIDTH +: IWIDTH]) * $signed(w_mat[i*IWIDTH +: IWIDTH]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sb0 <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_prod[i] <= '0;
            end
        end else begin
            r_sb0 <= w_in_sb;
            if (w_in_sb.valid) begin
                for (int i = 0; i < LANES; i++) begin
                    r_prod[i] <= w_prod[i];
                end
            end
        end
    end

    // Partial sums of every level, sign-extended to the widest level for uniform indexing.
    logic signed [c_SW-1:0] w_sum [c_LEVELS+1][LANES];
    sideband_t              w_sb  [c_LEVELS+1];

    assign w_sb[0] = r_sb0;
    for (genvar i = 0; i < LANES; i++) begin : g_lvl0
        assign w_sum[0][i] = c_SW'(r_prod[i]);
    end

    for (genvar k = 0; k < c_LEVELS; k++) begin : g_level
        localparam int c_N = LANES >> k;
        localparam int c_W = c_PW + k;

        logic [c_N*c_W-1:0]           w_in;
        logic [(c_N/2)*(c_W+1)-1:0]   w_out;

        for (genvar j = 0; j < c_N; j++) begin : g_pack
            assign w_in[j*c_W +: c_W] = w_sum[k][j][c_W-1:0];
        end

        dot_tree_level #(
            .N (c_N),
            .W (c_W)
        ) u_level (
            .clk    (clk),
            .rst    (rst),
            .i_sb   (w_sb[k]),
            .i_data (w_in),
            .o_sb   (w_sb[k+1]),
            .o_data (w_out)
        );

        for (genvar j = 0; j < LANES; j++) begin : g_unpack
            if (j < c_N/2) begin : g_live
                assign w_sum[k+1][j] = c_SW'($signed(w_out[j*(c_W+1) +: c_W+1]));
            end else begin : g_idle
                assign w_sum[k+1][j] = '0;
            end
        end
    end

    assign bus.result = OWIDTH'(w_sum[c_LEVELS][0]);
    assign bus.ovalid = w_sb[c_LEVELS].valid;
    assign bus.ofirst = w_sb[c_LEVELS].first;
    assign bus.olast  = w_sb[c_LEVELS].last;

endmodule

`default_nettype wire

// File: tb/tb_dot_product_tree.sv
// ============================================================================
// Module  : tb_dot_product_tree
// Brief   : Directed self-checking bench for dot_product_tree (LANES=8, IWIDTH=8).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dot_product_tree;

`ifdef DOT_PRODUCT_INPUT_REG_EN
    localparam int c_LAT = 5;
`else
    localparam int c_LAT = 4;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    dot_product_tree_if #(.LANES(8), .IWIDTH(8), .OWIDTH(32)) bus ();

    dot_product_tree #(
        .LANES  (8),
        .IWIDTH (8),
        .OWIDTH (32)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] fill(input int x);
        logic [7:0] b;
        b = x[7:0];
        return {8{b}};
    endfunction

    function automatic logic [63:0] ramp();
        logic [63:0] v;
        for (int i = 0; i < 8; i++) begin
            v[i*8 +: 8] = 8'(i + 1);
        end
        return v;
    endfunction

    task automatic set_beat(input logic v, input logic f, input logic l,
                            input logic [63:0] vv, input logic [63:0] mm);
        bus.ivalid = v;
        bus.first  = f;
        bus.last   = l;
        bus.vec    = vv;
        bus.mat    = mm;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic longint res();
        return longint'($signed(bus.result));
    endfunction

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst      = 1'b1;
        set_beat(1'b0, 1'b0, 1'b0, '0, '0);
        step(2);
        check_eq("rst_result", res(), 0);
        check_eq("rst_ovalid", longint'(bus.ovalid), 0);
        check_eq("rst_ofirst", longint'(bus.ofirst), 0);
        check_eq("rst_olast",  longint'(bus.olast), 0);
        rst = 1'b0;
        step(1);

        // Single-beat row of ones
        set_beat(1'b1, 1'b1, 1'b1, fill(1), fill(1));
        step(1);
        set_beat(1'b0, 1'b0, 1'b0, '0, '0);
        step(c_LAT - 2);
        check_eq("s1_pre_ovalid", longint'(bus.ovalid), 0);
        step(1);
        check_eq("s1_result", res(), 8);
        check_eq("s1_ovalid", longint'(bus.ovalid), 1);
        check_eq("s1_ofirst", longint'(bus.ofirst), 1);
        check_eq("s1_olast",  longint'(bus.olast), 1);
        step(1);
        check_eq("s1_post_ovalid", longint'(bus.ovalid), 0);
        check_eq("s1_post_ofirst", longint'(bus.ofirst), 0);
        check_eq("s1_post_hold",   res(), 8);

        // Width extremes
        set_beat(1'b1, 1'b1, 1'b0, fill(-128), fill(-128));
        step(1);
        set_beat(1'b1, 1'b0, 1'b1, fill(-128), fill(127));
        step(1);
        set_beat(1'b0, 1'b0, 1'b0, '0, '0);
        step(c_LAT - 2);
        check_eq("s2_maxpos", res(), 131072);
        check_eq("s2_olast0", longint'(bus.olast), 0);
        step(1);
        check_eq("s2_maxneg", res(), -130048);
        check_eq("s2_olast1", longint'(bus.olast), 1);

        // Back-to-back three-beat row
        set_beat(1'b1, 1'b1, 1'b0, ramp(), fill(1));
        step(1);
        set_beat(1'b1, 1'b0, 1'b0, fill(2), fill(3));
        step(1);
        set_beat(1'b1, 1'b0, 1'b1, fill(-1), fill(5));
        step(1);
        set_beat(1'b0, 1'b0, 1'b0, '0, '0);
        step(c_LAT - 3);
        check_eq("s3_b1_result", res(), 36);
        check_eq("s3_b1_ofirst", longint'(bus.ofirst), 1);
        check_eq("s3_b1_olast",  longint'(bus.olast), 0);
        step(1);
        check_eq("s3_b2_result", res(), 48);
        check_eq("s3_b2_ovalid", longint'(bus.ovalid), 1);
        check_eq("s3_b2_ofirst", longint'(bus.ofirst), 0);
        check_eq("s3_b2_olast",  longint'(bus.olast), 0);
        step(1);
        check_eq("s3_b3_result", res(), -40);
        check_eq("s3_b3_ofirst", longint'(bus.ofirst), 0);
        check_eq("s3_b3_olast",  longint'(bus.olast), 1);

        // Bubble with garbage data and flags must be ignored
        set_beat(1'b1, 1'b0, 1'b0, fill(1), fill(1));
        step(1);
        set_beat(1'b0, 1'b1, 1'b1, fill(127), fill(127));
        step(1);
        set_beat(1'b1, 1'b0, 1'b0, fill(2), fill(2));
        step(1);
        set_beat(1'b0, 1'b0, 1'b0, '0, '0);
        step(c_LAT - 3);
        check_eq("s4_b1_result", res(), 8);
        step(1);
        check_eq("s4_gap_ovalid", longint'(bus.ovalid), 0);
        check_eq("s4_gap_ofirst", longint'(bus.ofirst), 0);
        check_eq("s4_gap_olast",  longint'(bus.olast), 0);
        check_eq("s4_gap_hold",   res(), 8);
        step(1);
        check_eq("s4_b2_result", res(), 32);
        check_eq("s4_b2_ovalid", longint'(bus.ovalid), 1);

        // Asynchronous reset with beats in flight
        set_beat(1'b1, 1'b1, 1'b0, fill(3), fill(3));
        step(1);
        set_beat(1'b1, 1'b0, 1'b1, fill(4), fill(4));
        step(1);
        set_beat(1'b0, 1'b0, 1'b0, '0, '0);
        step(c_LAT - 2);
        check_eq("s5_pre_result", res(), 72);
        #2;
        rst = 1'b1;
        #1;
        check_eq("s5_rst_result", res(), 0);
        check_eq("s5_rst_ovalid", longint'(bus.ovalid), 0);
        check_eq("s5_rst_ofirst", longint'(bus.ofirst), 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check_eq("s5_post_ovalid", longint'(bus.ovalid), 0);
        end

        // Recovery after reset
        set_beat(1'b1, 1'b1, 1'b1, fill(-2), fill(7));
        step(1);
        set_beat(1'b0, 1'b0, 1'b0, '0, '0);
        step(c_LAT - 1);
        check_eq("s6_result", res(), -112);
        check_eq("s6_ovalid", longint'(bus.ovalid), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
